// File: rtl/bmem_pkg.sv
// Shared types and constants for the banked-memory line adapter.
// The adapter moves 256-bit cache lines as 4-beat 64-bit bmem bursts.
package bmem_pkg;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int LINE_W      = BEAT_W * BEATS;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } bmem_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } bmem_gnt_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter between the I-cache and D-cache.
// On a conflict the side that did not win last time gets the grant.
module rr_arbiter2
    import bmem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic gnt_d,
    output logic any_req
);
    bmem_gnt_t last_grant;
    bmem_gnt_t winner;

    always_comb begin
        winner = GNT_I;
        if (req_d && (!req_i || last_grant == GNT_I))
            winner = GNT_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GNT_I;
        else if (update && (req_i || req_d))
            last_grant <= winner;
    end

    assign gnt_d   = (winner == GNT_D);
    assign any_req = req_i | req_d;
endmodule

// File: rtl/bmem_line_adapter.sv
// Initiator side of the bmem port: arbitrates cache line fills and writebacks,
// splits each line into a 4-beat burst and assembles returning read beats.
module bmem_line_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic                      i_read,
    output logic [BEAT_W*BEATS-1:0]   i_rdata,
    output logic                      i_resp,
    input  logic [ADDR_W-1:0]         d_addr,
    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [BEAT_W*BEATS-1:0]   d_wdata,
    output logic [BEAT_W*BEATS-1:0]   d_rdata,
    output logic                      d_resp,
    output logic [ADDR_W-1:0]         bmem_addr,
    output logic                      bmem_read,
    output logic                      bmem_write,
    output logic [BEAT_W-1:0]         bmem_wdata,
    input  logic                      bmem_ready,
    input  logic [ADDR_W-1:0]         bmem_raddr,
    input  logic [BEAT_W-1:0]         bmem_rdata,
    input  logic                      bmem_rvalid
);
    import bmem_pkg::*;

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    bmem_state_t        state_q, state_d;
    bmem_gnt_t          gnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wbuf_q;
    logic [LINE_W-1:0]  asm_q;
    logic [LINE_W-1:0]  line_fill;
    logic [LINE_W-1:0]  i_rdata_q;
    logic [LINE_W-1:0]  d_rdata_q;
    logic [ADDR_W-1:0]  sel_addr;
    logic               gnt_d;
    logic               any_req;
    logic               arb_update;
    logic               beat_hit;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (i_read),
        .req_d   (d_read | d_write),
        .update  (arb_update),
        .gnt_d   (gnt_d),
        .any_req (any_req)
    );

    assign sel_addr = gnt_d ? d_addr : i_addr;
    assign beat_hit = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);

    // Incoming beat merged into the partial line so the final beat lands in the
    // per-side output register in the same cycle it arrives.
    always_comb begin
        line_fill = asm_q;
        line_fill[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_comb begin
        state_d    = state_q;
        arb_update = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            IDLE: begin
                arb_update = 1'b1;
                if (any_req)
                    state_d = (gnt_d && d_write) ? WR_BURST : RD_ISSUE;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_wdata = wbuf_q[cnt_q*BEAT_W +: BEAT_W];
                if (bmem_ready && cnt_q == LAST_BEAT)
                    state_d = RESP;
            end
            RD_ISSUE: begin
                bmem_read = 1'b1;
                if (bmem_ready)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (beat_hit && cnt_q == LAST_BEAT)
                    state_d = RESP;
            end
            RESP: begin
                i_resp  = (gnt_q == GNT_I);
                d_resp  = (gnt_q == GNT_D);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            cnt_q     <= '0;
            addr_q    <= '0;
            wbuf_q    <= '0;
            asm_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q  <= gnt_d ? GNT_D : GNT_I;
                        addr_q <= sel_addr & LINE_MASK;
                        cnt_q  <= '0;
                        if (gnt_d && d_write)
                            wbuf_q <= d_wdata;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready)
                        cnt_q <= cnt_q + 1'b1;
                end
                RD_WAIT: begin
                    if (beat_hit) begin
                        asm_q <= line_fill;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            if (gnt_q == GNT_D)
                                d_rdata_q <= line_fill;
                            else
                                i_rdata_q <= line_fill;
                        end
                    end
                end
                RESP: cnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign bmem_addr = addr_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

    // A stray tag is tolerated in hardware but points at a memory-side bug;
    // a dropped request leaves the burst running to completion.
    always @(posedge clk) begin
        if (!rst) begin
            if (state_q == RD_WAIT && bmem_rvalid)
                assert (bmem_raddr == addr_q)
                    else $warning("bmem_line_adapter: read tag %h differs from burst %h", bmem_raddr, addr_q);
            if (state_q != IDLE)
                assert ((gnt_q == GNT_D) ? (d_read || d_write) : i_read)
                    else $error("bmem_line_adapter: request dropped before response");
        end
    end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// Scoreboard bench for bmem_line_adapter: expected responses and write beats are
// queued at stimulus time and compared when the adapter produces them.
module tb_bmem_line_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
    logic         i_read, d_read, d_write, i_resp, d_resp;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [63:0]  bmem_wdata, bmem_rdata;

    typedef struct {
        logic         side;
        logic         chk;
        logic [255:0] line;
    } exp_t;

    exp_t        resp_q[$];
    logic [63:0] wbeat_q[$];
    logic [31:0] wr_addr;
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    bmem_line_adapter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] s);
        logic [255:0] l;
        for (int k = 0; k < 4; k++)
            l[64*k +: 64] = {s, 24'h5a5a00, 8'(k + 1)} ^ {32'(k) * 32'h0101_0101, 32'h0};
        return l;
    endfunction

    function automatic exp_t mk_exp(input logic side, input logic chk, input logic [255:0] line);
        exp_t e;
        e.side = side;
        e.chk  = chk;
        e.line = line;
        return e;
    endfunction

    // Response and write-beat scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (i_resp || d_resp) begin
                if (resp_q.size() == 0)
                    check("resp_unexpected", i_resp | d_resp, 0);
                else begin
                    mon_e = resp_q.pop_front();
                    check("resp_side", d_resp, mon_e.side);
                    check("resp_both", i_resp & d_resp, 0);
                    if (mon_e.chk)
                        check("resp_line", mon_e.side ? d_rdata : i_rdata, mon_e.line);
                end
            end
            if (bmem_write && bmem_ready) begin
                if (wbeat_q.size() == 0)
                    check("wr_unexpected", bmem_write, 0);
                else begin
                    check("wr_beat", bmem_wdata, wbeat_q.pop_front());
                    check("wr_addr", bmem_addr, wr_addr);
                end
            end
            check("rd_wr_excl", bmem_read & bmem_write, 0);
        end
    end

    // pat holds 2-bit slots: 0 idle, 1 good beat, 2 beat with a wrong tag; past slot 7 all good
    task automatic serve_read(input logic [31:0] addr, input logic [255:0] line, input logic [15:0] pat);
        int       k;
        int       slot;
        logic [1:0] code;
        bit       seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bmem_read) seen = 1'b1;
        end
        check("rd_issue", seen, 1);
        if (!seen) return;
        check("rd_addr", bmem_addr, addr);
        k = 0;
        slot = 0;
        while (k < 4) begin
            @(posedge clk); #1;
            code        = (slot < 8) ? pat[2*slot +: 2] : 2'd1;
            bmem_rvalid = (code != 2'd0);
            bmem_raddr  = (code == 2'd2) ? (addr ^ 32'h0000_0100) : addr;
            bmem_rdata  = (code == 2'd1) ? line[64*k +: 64] : 64'hdead_beef_0bad_f00d;
            if (code == 2'd1) k++;
            slot++;
            @(negedge clk);
            check("rd_no_early_resp", i_resp | d_resp, 0);
            check("rd_single_issue", bmem_read, 0);
        end
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        check("rd_resp", i_resp | d_resp, 1);
    endtask

    task automatic end_req(input logic side);
        @(posedge clk); #1;
        if (side) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else
            i_read = 1'b0;
        @(negedge clk);
        check("resp_pulse", i_resp | d_resp, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [255:0] l1, l2, ld1, ld2, li1, l4, l5, l6, l7;
    bit           seen;

    initial begin
        rst = 1'b1;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        wr_addr = '0;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l2  = mk_line(32'hc0de_0002);
        ld1 = mk_line(32'h0d00_0001);
        ld2 = mk_line(32'h0d00_0002);
        li1 = mk_line(32'h0100_0001);
        l4  = mk_line(32'h0000_4444);
        l5  = mk_line(32'h0000_5555);
        l6  = mk_line(32'h0000_6666);
        l7  = mk_line(32'h0000_7777);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {bmem_read, bmem_write, i_resp, d_resp}, 0);
        check("rst_addr", bmem_addr, 0);
        check("rst_wdata", bmem_wdata, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // I fill with back-to-back beats; low address bits must be dropped
        @(posedge clk); #1;
        i_addr = 32'h0000_104c; i_read = 1'b1; bmem_ready = 1'b1;
        resp_q.push_back(mk_exp(1'b0, 1'b1, l1));
        serve_read(32'h0000_1040, l1, 16'h5555);
        end_req(1'b0);

        // D writeback with a 3-cycle stall on the second beat
        wr_addr = 32'h8000_0020;
        for (int k = 0; k < 4; k++) wbeat_q.push_back(l2[64*k +: 64]);
        resp_q.push_back(mk_exp(1'b1, 1'b0, '0));
        @(posedge clk); #1;
        d_addr = 32'h8000_0020; d_wdata = l2; d_write = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bmem_write) seen = 1'b1;
        end
        check("wr_issue", seen, 1);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            bmem_ready = (j >= 3);
            @(negedge clk);
            check("wr_held", bmem_write, 1);
            check("wr_no_early_resp", d_resp, 0);
            if (j < 3) check("wr_stall_data", bmem_wdata, l2[127:64]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_resp", d_resp, 1);
        check("wr_no_fill", d_rdata, 0);
        end_req(1'b1);
        check("wr_beats_done", wbeat_q.size(), 0);

        // Simultaneous requests: D wins after reset, then I on the next conflict
        do_reset();
        @(posedge clk); #1;
        i_addr = 32'h0000_2000; i_read = 1'b1;
        d_addr = 32'h0000_3000; d_read = 1'b1;
        resp_q.push_back(mk_exp(1'b1, 1'b1, ld1));
        resp_q.push_back(mk_exp(1'b0, 1'b1, li1));
        serve_read(32'h0000_3000, ld1, 16'h5555);
        @(posedge clk); #1;
        d_addr = 32'h0000_3040;
        resp_q.push_back(mk_exp(1'b1, 1'b1, ld2));
        serve_read(32'h0000_2000, li1, 16'h5555);
        check("d_rdata_hold", d_rdata, ld1);
        end_req(1'b0);
        serve_read(32'h0000_3040, ld2, 16'h5555);
        end_req(1'b1);
        check("i_rdata_hold", i_rdata, li1);

        // Read beats with gaps: 1,0,0,1,1,0,1
        @(posedge clk); #1;
        i_addr = 32'h0000_4000; i_read = 1'b1;
        resp_q.push_back(mk_exp(1'b0, 1'b1, l4));
        serve_read(32'h0000_4000, l4, 16'h5141);
        end_req(1'b0);

        // A beat with the wrong tag in the middle is dropped
        @(posedge clk); #1;
        i_addr = 32'h0000_5000; i_read = 1'b1;
        resp_q.push_back(mk_exp(1'b0, 1'b1, l5));
        serve_read(32'h0000_5000, l5, 16'h5559);
        end_req(1'b0);

        // Reset in the middle of a read, stale beats afterwards, then a clean fill
        @(posedge clk); #1;
        i_addr = 32'h0000_6000; i_read = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bmem_read) seen = 1'b1;
        end
        check("mid_issue", seen, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_6000; bmem_rdata = l6[64*k +: 64];
        end
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
        rst = 1'b1;
        i_read = 1'b0;
        @(negedge clk);
        check("mid_rst_ctrl", {bmem_read, bmem_write, i_resp, d_resp}, 0);
        check("mid_rst_addr", bmem_addr, 0);
        check("mid_rst_i_rdata", i_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 2; k < 4; k++) begin
            @(posedge clk); #1;
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_6000; bmem_rdata = l6[64*k +: 64];
            @(negedge clk);
            check("stale_idle", {bmem_read, i_resp, d_resp}, 0);
        end
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
        i_addr = 32'h0000_6000; i_read = 1'b1;
        resp_q.push_back(mk_exp(1'b0, 1'b1, l7));
        serve_read(32'h0000_6000, l7, 16'h5555);
        end_req(1'b0);

        repeat (2) @(negedge clk);
        check("resp_q_drained", resp_q.size(), 0);
        check("wbeat_q_drained", wbeat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
